// File: rtl/io_port_responder_if.sv
// Request/response bus between the external interface unit (master) and io_port_responder (slave).
// Optional IO_PORT_RSP_ERR_EN adds the o_rsp_err response flag.
interface io_port_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    // Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender keeps valid and its payload stable until then, and ready may change freely.
    logic              i_req_valid;
    logic              i_req_write;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;
    logic              o_req_ready;
    logic              o_rsp_valid;
    logic [DATA_W-1:0] o_rsp_data;
    logic              i_rsp_ready;
`ifdef IO_PORT_RSP_ERR_EN
    logic              o_rsp_err;
`endif

    modport slave (
        input  i_req_valid,
        input  i_req_write,
        input  i_req_addr,
        input  i_req_wdata,
        input  i_rsp_ready,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_data
`ifdef IO_PORT_RSP_ERR_EN
        , output o_rsp_err
`endif
    );

    modport master (
        output i_req_valid,
        output i_req_write,
        output i_req_addr,
        output i_req_wdata,
        output i_rsp_ready,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_data
`ifdef IO_PORT_RSP_ERR_EN
        , input o_rsp_err
`endif
    );
endinterface

// File: rtl/io_port_responder.sv
// Register-bank endpoint: one outstanding read/write, reads answered after WAIT_CYC wait states.
// Optional IO_PORT_RSP_ERR_EN flags out-of-range accesses on o_rsp_err. rst_n is active-high.
module io_port_responder #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    io_port_responder_if.slave bus,
    output logic [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int               CNT_W       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] LP_CNT_LOAD = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

    state_t            r_state;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_bank [NUM_REGS];

    logic              w_req_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd_now;
    logic [DATA_W-1:0] w_rd_lat;

`ifdef IO_PORT_RSP_ERR_EN
    localparam logic [ADDR_W:0] LP_NUM = (ADDR_W + 1)'(NUM_REGS);
    logic r_oor;
    logic r_rsp_err;
    logic w_req_oor;
    assign w_req_oor     = ({1'b0, bus.i_req_addr} >= LP_NUM);
    assign bus.o_rsp_err = r_rsp_err;
`endif

    // Reset masks ready combinationally so nothing is offered while reset is held.
    assign w_req_ready     = r_req_ready & ~rst_n;
    assign w_accept        = bus.i_req_valid & w_req_ready;
    assign bus.o_req_ready = w_req_ready;
    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_data  = r_rsp_data;
    assign o_dbg_state     = r_state;

    // Full-address decode: unmatched addresses read as zero, so no aliasing above NUM_REGS.
    always_comb begin
        w_rd_now = '0;
        w_rd_lat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.i_req_addr == ADDR_W'(i)) w_rd_now = r_bank[i];
            if (r_addr == ADDR_W'(i))         w_rd_lat = r_bank[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_accept && bus.i_req_write && bus.i_req_addr == ADDR_W'(i))
                    r_bank[i] <= bus.i_req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
`ifdef IO_PORT_RSP_ERR_EN
            r_oor       <= 1'b0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        r_addr      <= bus.i_req_addr;
                        r_req_ready <= 1'b0;
`ifdef IO_PORT_RSP_ERR_EN
                        r_oor       <= w_req_oor;
`endif
                        if (bus.i_req_write) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
`ifdef IO_PORT_RSP_ERR_EN
                            r_rsp_err   <= w_req_oor;
`endif
                        end else if (WAIT_CYC == 0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_rd_now;
`ifdef IO_PORT_RSP_ERR_EN
                            r_rsp_err   <= w_req_oor;
`endif
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= LP_CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rd_lat;
`ifdef IO_PORT_RSP_ERR_EN
                        r_rsp_err   <= r_oor;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Ready rises only after the handshake edge, so no accept overlaps it.
                    if (bus.i_rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
`ifdef IO_PORT_RSP_ERR_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_data  <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Peripheral-side endpoint of the processor's external interface unit.
- Accepts one read/write request at a time from the processor and serves it from a local register bank.
- Returns read data after a programmable number of wait states, using a valid/ready response handshake.
- Response data is zero whenever not valid, so it can be OR-combined onto a shared data bus with other sources.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 4, request address width.
- NUM_REGS, 12, number of implemented registers (addresses 0..NUM_REGS-1); must be <= 2^ADDR_W.
- WAIT_CYC, 2, wait states inserted before a read response (0 allowed).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-high despite the name; sampled on clk rising edge.
- i_req_valid  in  1  request present.
- i_req_write  in  1  1 = write, 0 = read; qualified by i_req_valid.
- i_req_addr  in  ADDR_W  register address.
- i_req_wdata  in  DATA_W  write data.
- o_req_ready  out  1  responder can accept a request.
- o_rsp_valid  out  1  response present.
- o_rsp_data  out  DATA_W  read data; zero for write responses and whenever o_rsp_valid=0.
- i_rsp_ready  in  1  processor consumes the response.

Behaviour:
- Reset (rst_n=1 at a clock edge): state=IDLE, o_req_ready=0 during the reset cycle, o_rsp_valid=0, o_rsp_data=0, wait counter=0, all registers=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - Request accepted on a cycle with i_req_valid & o_req_ready.
  - Write accept: bank[addr] <= wdata on the same edge, if addr < NUM_REGS. Next state RESP with data 0.
  - Read accept: latch addr. Next state WAIT if WAIT_CYC>0 (counter loaded with WAIT_CYC-1), else RESP.
- WAIT:
  - o_req_ready=0.
  - Counter decrements each cycle; at 0, next state RESP.
  - Read latency, accept edge to first o_rsp_valid: exactly WAIT_CYC+1 cycles.
- RESP:
  - o_rsp_valid=1; o_rsp_data = bank[latched addr], or 0 if addr >= NUM_REGS or the request was a write.
  - Data registered on RESP entry and held stable until handshake.
  - Handshake (o_rsp_valid & i_rsp_ready): next state IDLE; o_rsp_valid and o_rsp_data drop to 0 the following cycle.
  - i_rsp_ready low: hold indefinitely, no timeout.
- Single outstanding request. o_req_ready is 0 in WAIT and RESP, so a new request is not accepted in the handshake cycle.
- Out-of-range writes are dropped silently; out-of-range reads return 0.
- Address bits above the range needed for NUM_REGS are not aliased; full-address compare.
- Inputs other than i_req_valid, i_rsp_ready and rst_n are don't-care when not qualified.
- Reset mid-operation (WAIT or RESP): abort. Next cycle state=IDLE, o_rsp_valid=0, bank cleared, the in-flight request is lost with no response.
- Reset dominates a simultaneous request accept or response handshake.

Optional Feature:
- Macro IO_PORT_RSP_ERR_EN.
- Defined:
  - Adds output o_rsp_err (1 bit, reset 0).
  - o_rsp_err=1 alongside o_rsp_valid when the request address >= NUM_REGS (read or write).
  - o_rsp_err is 0 whenever o_rsp_valid=0.
  - Data behaviour is unchanged.
- Not defined: port absent; out-of-range accesses are indistinguishable except by zero read data.

Test Plan:
- Reset then write addr 3 = 0xA5A5, read addr 3 with i_rsp_ready=1 -> write response data 0; read o_rsp_valid rises exactly 3 cycles after accept (WAIT_CYC=2) with data 0xA5A5.
- WAIT_CYC=0 build, read addr 0 after writing 0x1234 -> o_rsp_valid the cycle after accept, data 0x1234.
- Read addr 5 (0x00FF) with i_rsp_ready held 0 for 10 cycles -> o_rsp_valid and data 0x00FF stable all 10 cycles, o_req_ready=0; request offered meanwhile not accepted.
- Write addr 13 = 0xFFFF, then read addr 13 -> both complete; read data 0; with IO_PORT_RSP_ERR_EN, o_rsp_err=1 on both responses.
- Assert rst_n during WAIT of a read to addr 2 (holding 0x0042) -> no response; IDLE next cycle; a subsequent read of addr 2 returns 0.
- Back-to-back writes to addr 1 with i_req_valid held high -> each accepted only in IDLE, one per completed handshake; final readback equals the last value written.
